// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 stream demux and its per-port buffers.
package demux_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = 2;
    localparam int PORT0     = 0;
    localparam int PORT1     = 1;

    // Occupancy after one cycle of optional push and optional pop.
    function automatic logic [OCC_W-1:0] occ_next(input logic [OCC_W-1:0] occ,
                                                  input logic push, input logic pop);
        logic [OCC_W-1:0] r;
        r = occ;
        if (push && !pop)
            r = occ + OCC_W'(1);
        else if (!push && pop)
            r = occ - OCC_W'(1);
        return r;
    endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry valid/ready FIFO. The head word is read from the storage
// registers, so it holds steady while the consumer stalls.
module stream_buf2
    import demux_pkg::*;
#(
    parameter int N = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [N-1:0] din,
    output logic         full,
    output logic         empty,
    input  logic         ready,
    output logic [N-1:0] dout
);

    logic [BUF_DEPTH-1:0][N-1:0] mem;
    logic                        wr_ptr;
    logic                        rd_ptr;
    logic [OCC_W-1:0]            occ;
    logic                        push_ok;
    logic                        pop;

    assign full    = (occ == OCC_W'(BUF_DEPTH));
    assign empty   = (occ == '0);
    assign push_ok = push && !full;
    assign pop     = !empty && ready;
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; push and pop may share a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ_next(occ, push_ok, pop);
        end
    end

endmodule

// File: rtl/demux2_stream.sv
// 1-to-2 stream demultiplexer. Each output owns a 2-entry buffer so a stalled
// consumer only blocks beats aimed at it; s_ready depends only on s_sel and
// registered occupancy, never on the output ready inputs.
module demux2_stream
    import demux_pkg::*;
#(
    parameter int N  = 128,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [N-1:0]  s_data,
    input  logic          s_sel,
    output logic          m0_valid,
    input  logic          m0_ready,
    output logic [N-1:0]  m0_data,
    output logic          m1_valid,
    input  logic          m1_ready,
    output logic [N-1:0]  m1_data,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    logic [1:0]         full;
    logic [1:0]         empty;
    logic [1:0]         push;
    logic [1:0]         rdy;
    logic [1:0][N-1:0]  dout;
    logic [1:0][CW-1:0] cnt;
    logic               accept;

    assign s_ready = !full[s_sel];
    assign accept  = s_valid && s_ready;
    assign rdy     = {m1_ready, m0_ready};

    generate
        for (genvar k = 0; k < 2; k++) begin : g_port
            assign push[k] = accept && (s_sel == 1'(k));

            stream_buf2 #(.N(N)) u_buf (
                .clk   (clk),
                .rst   (rst),
                .push  (push[k]),
                .din   (s_data),
                .full  (full[k]),
                .empty (empty[k]),
                .ready (rdy[k]),
                .dout  (dout[k])
            );
        end
    endgenerate

    // Per-port accepted-beat counters, wrapping naturally at 2^CW.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (push[k])
                    cnt[k] <= cnt[k] + CW'(1);
        end
    end

    assign m0_valid = !empty[PORT0];
    assign m1_valid = !empty[PORT1];
    assign m0_data  = dout[PORT0];
    assign m1_data  = dout[PORT1];
    assign cnt0     = cnt[PORT0];
    assign cnt1     = cnt[PORT1];

endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: hand sequences, a vector table, and random
// traffic checked against a queue-based model of the two ports.
module tb_demux2_stream;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, s_sel;
    logic [N-1:0]  s_data;
    logic          m0_valid, m0_ready, m1_valid, m1_ready;
    logic [N-1:0]  m0_data, m1_data;
    logic [CW-1:0] cnt0, cnt1;

    demux2_stream #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sel(s_sel),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_data(m0_data),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per port plus plain integer counters.
    logic [N-1:0] q0[$], q1[$], out0[$], out1[$];
    int           c0, c1;
    int           n_chk = 0, n_fail = 0;
    bit           chk_en = 0;

    typedef struct {
        logic sv; logic sel; logic [7:0] d; logic r0; logic r1;
        logic srdy; logic m0v; logic [7:0] m0d; logic m1v; logic [7:0] m1d;
        int c0; int c1;
    } vec_t;
    vec_t tbl[11];

    function automatic vec_t mk(logic sv, logic sel, logic [7:0] d, logic r0, logic r1,
                                logic srdy, logic m0v, logic [7:0] m0d,
                                logic m1v, logic [7:0] m1d, int ec0, int ec1);
        vec_t v;
        v.sv = sv; v.sel = sel; v.d = d; v.r0 = r0; v.r1 = r1;
        v.srdy = srdy; v.m0v = m0v; v.m0d = m0d; v.m1v = m1v; v.m1d = m1d;
        v.c0 = ec0; v.c1 = ec1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: compare DUT against model before the edge, advance model after it.
    task automatic cycle();
        bit acc, p0, p1;
        logic [N-1:0] d;
        @(negedge clk);
        if (chk_en) begin
            chk("s_ready", s_ready, (s_sel ? q1.size() : q0.size()) < 2);
            chk("m0_valid", m0_valid, q0.size() != 0);
            chk("m1_valid", m1_valid, q1.size() != 0);
            if (q0.size() != 0) chk("m0_data", m0_data, q0[0]);
            if (q1.size() != 0) chk("m1_data", m1_data, q1[0]);
            chk("cnt0", cnt0, c0);
            chk("cnt1", cnt1, c1);
        end
        acc = s_valid && ((s_sel ? q1.size() : q0.size()) < 2);
        p0  = (q0.size() != 0) && m0_ready;
        p1  = (q1.size() != 0) && m1_ready;
        d   = s_data;
        @(posedge clk);
        if (rst) begin
            q0.delete(); q1.delete(); c0 = 0; c1 = 0;
        end else begin
            if (p0) out0.push_back(q0.pop_front());
            if (p1) out1.push_back(q1.pop_front());
            if (acc) begin
                if (s_sel) begin q1.push_back(d); c1 = (c1 + 1) % (1 << CW); end
                else        begin q0.push_back(d); c0 = (c0 + 1) % (1 << CW); end
            end
        end
        #1;
    endtask

    task automatic drive(input logic sv, input logic sel, input logic [7:0] d,
                         input logic r0, input logic r1);
        s_valid = sv; s_sel = sel; s_data = d; m0_ready = r0; m1_ready = r1;
    endtask

    // Selecting a port with an unknown s_sel is a producer protocol error.
    always @(posedge clk)
        if (!rst && s_valid)
            assert (!$isunknown(s_sel)) else $error("FAIL s_sel unknown while s_valid");

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mk(1, 1, 8'hA5, 0, 1,  1, 0, 8'h00, 0, 8'h00, 0, 0);
        tbl[1]  = mk(0, 0, 8'h00, 0, 1,  1, 0, 8'h00, 1, 8'hA5, 0, 1);
        tbl[2]  = mk(1, 0, 8'h11, 0, 1,  1, 0, 8'h00, 0, 8'h00, 0, 1);
        tbl[3]  = mk(1, 0, 8'h22, 0, 1,  1, 1, 8'h11, 0, 8'h00, 1, 1);
        tbl[4]  = mk(1, 0, 8'h33, 0, 1,  0, 1, 8'h11, 0, 8'h00, 2, 1);
        tbl[5]  = mk(1, 0, 8'h33, 0, 1,  0, 1, 8'h11, 0, 8'h00, 2, 1);
        tbl[6]  = mk(1, 1, 8'h44, 0, 1,  1, 1, 8'h11, 0, 8'h00, 2, 1);
        tbl[7]  = mk(1, 0, 8'h33, 1, 1,  0, 1, 8'h11, 1, 8'h44, 2, 2);
        tbl[8]  = mk(1, 0, 8'h33, 1, 1,  1, 1, 8'h22, 0, 8'h00, 2, 2);
        tbl[9]  = mk(0, 0, 8'h00, 1, 1,  1, 1, 8'h33, 0, 8'h00, 3, 2);
        tbl[10] = mk(0, 0, 8'h00, 1, 1,  1, 0, 8'h00, 0, 8'h00, 3, 2);

        // Reset then idle.
        rst = 1'b1;
        drive(0, 0, 8'h00, 0, 0);
        cycle();
        cycle();
        rst = 1'b0;
        chk_en = 1;
        s_sel = 1'b0; #1 chk("rst s_ready sel0", s_ready, 1);
        s_sel = 1'b1; #1 chk("rst s_ready sel1", s_ready, 1);
        chk("rst m0_valid", m0_valid, 0);
        chk("rst m1_valid", m1_valid, 0);
        chk("rst cnt0", cnt0, 0);
        chk("rst cnt1", cnt1, 0);
        chk("rst m0_data", m0_data, 0);
        chk("rst m1_data", m1_data, 0);

        // Single steer, back-pressure fill, head-of-line isolation.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].sv, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
            #1;
            chk($sformatf("vec%0d s_ready", i), s_ready, tbl[i].srdy);
            chk($sformatf("vec%0d m0_valid", i), m0_valid, tbl[i].m0v);
            chk($sformatf("vec%0d m1_valid", i), m1_valid, tbl[i].m1v);
            if (tbl[i].m0v) chk($sformatf("vec%0d m0_data", i), m0_data, tbl[i].m0d);
            if (tbl[i].m1v) chk($sformatf("vec%0d m1_data", i), m1_data, tbl[i].m1d);
            chk($sformatf("vec%0d cnt0", i), cnt0, tbl[i].c0);
            chk($sformatf("vec%0d cnt1", i), cnt1, tbl[i].c1);
            cycle();
        end

        // Streaming: 16 alternating beats, both consumers always ready.
        rst = 1'b1; drive(0, 0, 8'h00, 1, 1); cycle(); rst = 1'b0;
        out0.delete(); out1.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1, i[0], 8'h80 + 8'(i), 1, 1);
            #1 chk("stream s_ready", s_ready, 1);
            cycle();
        end
        drive(0, 0, 8'h00, 1, 1);
        cycle();
        chk("stream out0 count", out0.size(), 8);
        chk("stream out1 count", out1.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < out0.size()) chk("stream out0 order", out0[i], 8'h80 + 8'(2 * i));
            if (i < out1.size()) chk("stream out1 order", out1[i], 8'h81 + 8'(2 * i));
        end
        chk("stream cnt0", cnt0, 8);
        chk("stream cnt1", cnt1, 8);

        // Reset with both buffers full discards everything.
        drive(1, 0, 8'hC0, 0, 0); cycle();
        drive(1, 0, 8'hC1, 0, 0); cycle();
        drive(1, 1, 8'hD0, 0, 0); cycle();
        drive(1, 1, 8'hD1, 0, 0); cycle();
        drive(0, 0, 8'h00, 0, 0);
        #1;
        chk("full port0 s_ready", s_ready, 0);
        chk("full m0_valid", m0_valid, 1);
        chk("full m1_valid", m1_valid, 1);
        rst = 1'b1; cycle(); rst = 1'b0;
        drive(0, 0, 8'h00, 1, 1);
        #1;
        chk("post-rst m0_valid", m0_valid, 0);
        chk("post-rst m1_valid", m1_valid, 0);
        out0.delete(); out1.delete();
        for (int i = 0; i < 3; i++) cycle();
        chk("post-rst no stale beats", out0.size() + out1.size(), 0);

        // Counter wrap: 17 beats to port 0 with a 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 8'(i), 1, 0);
            cycle();
        end
        drive(0, 0, 8'h00, 1, 0);
        #1;
        chk("wrap cnt0", cnt0, 1);
        chk("wrap cnt1", cnt1, 0);
        cycle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
            cycle();
        end
        rst = 1'b0;
        drive(0, 0, 8'h00, 1, 1);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demux2_stream.md
Name: demux2_stream

Overview:
- 1-to-2 stream demultiplexer with valid/ready handshaking. It is the fan-out counterpart of the 2:1 data-select mux used on the datapath.
- Each input beat carries an N-bit word plus a select bit, and is steered to output port 0 or port 1.
- Each output has its own 2-entry buffer. A stalled port therefore blocks only beats that target it.
- Sits between a single producer and two independent consumers; per-port accept counters support debug and status readout.

Parameters:
- N, 128, data width in bits.
- CW, 16, width of the per-port accepted-beat counters.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- s_valid, input, 1, input beat valid.
- s_ready, output, 1, input beat accepted when s_valid && s_ready.
- s_data, input, N, input word.
- s_sel, input, 1, destination: 0 = port 0, 1 = port 1.
- m0_valid, output, 1, port 0 word valid.
- m0_ready, input, 1, port 0 consumer ready.
- m0_data, output, N, port 0 word.
- m1_valid, output, 1, port 1 word valid.
- m1_ready, input, 1, port 1 consumer ready.
- m1_data, output, N, port 1 word.
- cnt0, output, CW, beats accepted for port 0.
- cnt1, output, CW, beats accepted for port 1.

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. All state changes on the rising edge of clk.
- Reset values:
  - m0_valid = m1_valid = 0.
  - Both buffers empty (occupancy 0, read/write pointers 0).
  - cnt0 = cnt1 = 0.
  - m*_data = 0.
  - s_ready follows occupancy, so it reads 1 right after reset.
- Reset mid-operation discards all buffered beats. No beat is presented after the reset edge.
- s_ready = s_sel ? (occ1 != 2) : (occ0 != 2).
  - Purely combinational from s_sel and registered occupancy.
  - Never depends on s_valid or on m*_ready, so there is no combinational ready path from output to input.
- Accept event: s_valid && s_ready.
  - The word is written into buffer[s_sel] at the write pointer.
  - The occupancy of that buffer increments.
  - cnt[s_sel] increments and wraps modulo 2^CW.
- Latency:
  - A beat accepted in cycle t appears on m*_valid/m*_data in cycle t+1 if that buffer was empty.
  - Otherwise it appears after the older entries drain.
- Output side:
  - m_k_valid = (occ_k != 0).
  - m_k_data = entry at read pointer, driven from a register, stable while valid && !ready.
  - Pop event: m_k_valid && m_k_ready.
- Simultaneous push and pop on the same buffer: occupancy unchanged and both pointers advance.
  - At occ = 1 this sustains 1 beat/cycle.
  - At occ = 2 a push cannot happen, because s_ready is low.
- Ordering: per-port FIFO order is preserved. No ordering guarantee between ports.
- Independence: a full port 1 with m1_ready = 0 does not stall beats with s_sel = 0.
- Pointers are 1 bit each and wrap 1 -> 0. Occupancy is 2 bits, with a maximum value of 2.
- An s_sel value presented while s_valid = 0 has no effect on state.
- X on s_data is stored as-is; X on s_sel while s_valid = 1 is illegal (bench assertion).

Decomposition:
- Small shared package demux_pkg holds:
  - BUF_DEPTH = 2.
  - Occupancy width constant OCC_W = 2.
  - Port index localparams PORT0 = 0, PORT1 = 1.
- One sub-module, stream_buf2: 2-entry valid/ready FIFO with full/empty flags and registered output, parameterised on N.
  - Instantiated twice.
  - Top level holds the select decode, s_ready mux and counters.

Test Plan:
1. Reset then idle, N=8:
   - Stimulus: assert rst for 2 cycles, then release.
   - Required response: m0_valid = m1_valid = 0, cnt0 = cnt1 = 0, s_ready = 1 for both s_sel values.
2. Single steer:
   - Stimulus: s_valid=1, s_sel=1, s_data=0xA5 for one cycle, m1_ready=1.
   - Required response: the next cycle shows m1_valid=1, m1_data=0xA5 and m0_valid=0; cnt1=1.
3. Back-pressure fill:
   - Stimulus: m0_ready=0; push 0x11, 0x22, 0x33 to port 0.
   - Required response:
     - The first two beats are accepted.
     - s_ready drops while s_sel=0 and the third beat is held.
     - Raising m0_ready yields 0x11, 0x22, 0x33 in order; cnt0=3.
4. Head-of-line isolation:
   - Stimulus: port 0 full with m0_ready=0, then push 0x44 with s_sel=1 and m1_ready=1.
   - Required response: 0x44 is accepted immediately and appears on m1 one cycle later.
5. Streaming:
   - Stimulus: 16 consecutive beats alternating s_sel, both m_ready held at 1.
   - Required response: s_ready stays 1 throughout, each port delivers 8 beats in order, cnt0 = cnt1 = 8.
6. Reset mid-flight and wrap:
   - Stimulus, part 1: with both buffers holding 2 beats, assert rst for 1 cycle.
   - Required response, part 1: all valids are 0 next cycle and no stale data appears.
   - Stimulus, part 2: with CW=4, push 17 beats to port 0.
   - Required response, part 2: cnt0 = 1.
